fp16_vdiv_seq: RTL and testbench

//  Vector-to-scalar sequencer that sits directly upstream of the FP16 iterative divider (FP16_div).
//  - Accepts a packed vector of LANES dividend/divisor pairs from the vector issue logic.
//  - Feeds the pairs to the single divider one lane at a time and collects each quotient.
//  - Returns the packed quotient vector with per-lane divide-by-zero and timeout flags.

---
 rtl/fp16_div_pkg.sv | 25 ++
 rtl/fp16_vdiv_seq.sv | 158 +++++++++++++++
 tb/tb_fp16_vdiv_seq.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp16_div_pkg.sv
// Shared definitions for the FP16 divider and its vector sequencer:
// FSM state encoding, FP16 field positions and small field helpers.
package fp16_div_pkg;

    localparam int FP16_W       = 16;
    localparam int FP16_SIGN    = 15;
    localparam int FP16_EXP_HI  = 14;
    localparam int FP16_EXP_LO  = 10;
    localparam int FP16_MAN_HI  = 9;
    localparam int FP16_MAN_LO  = 0;
    localparam logic [14:0] FP16_SAT = 15'h7FFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_NEXT  = 2'd3
    } seq_state_t;

    // True for +0 and -0: sign is ignored, exponent and mantissa both zero.
    function automatic logic is_zero_mag(input logic [FP16_W-1:0] v);
        return (v[FP16_EXP_HI:FP16_EXP_LO] == '0) && (v[FP16_MAN_HI:FP16_MAN_LO] == '0);
    endfunction

endpackage

// File: rtl/fp16_vdiv_seq.sv
// Serialises a LANES-wide FP16 divide onto one iterative divider, one lane at a time,
// and returns the packed quotients with per-lane divide-by-zero and timeout flags.
module fp16_vdiv_seq
    import fp16_div_pkg::*;
#(
    parameter int LANES   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [FP16_W*LANES-1:0] vec_x,
    input  logic [FP16_W*LANES-1:0] vec_d,
    output logic                    busy,
    output logic                    done,
    output logic [FP16_W*LANES-1:0] vec_q,
    output logic [LANES-1:0]        dz_flag,
    output logic [LANES-1:0]        to_flag,
    output logic [FP16_W-1:0]       div_dividend,
    output logic [FP16_W-1:0]       div_divisor,
    output logic                    div_valid,
    input  logic                    div_idle,
    input  logic                    div_update,
    input  logic [FP16_W-1:0]       div_q
);

    localparam int VW = FP16_W * LANES;
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    seq_state_t        state_q, state_d;
    logic [LW-1:0]     lane_q, lane_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [VW-1:0]     op_x_q, op_x_d;
    logic [VW-1:0]     op_d_q, op_d_d;
    logic [VW-1:0]     vec_q_q, vec_q_d;
    logic [LANES-1:0]  dz_q, dz_d;
    logic [LANES-1:0]  to_q, to_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              div_valid_q, div_valid_d;
    logic [FP16_W-1:0] div_dividend_q, div_dividend_d;
    logic [FP16_W-1:0] div_divisor_q, div_divisor_d;

    logic [FP16_W-1:0] lane_x, lane_dv;

    assign lane_x  = op_x_q[lane_q*FP16_W +: FP16_W];
    assign lane_dv = op_d_q[lane_q*FP16_W +: FP16_W];

    always_comb begin
        state_d        = state_q;
        lane_d         = lane_q;
        tmo_d          = tmo_q;
        op_x_d         = op_x_q;
        op_d_d         = op_d_q;
        vec_q_d        = vec_q_q;
        dz_d           = dz_q;
        to_d           = to_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        div_valid_d    = 1'b0;
        div_dividend_d = div_dividend_q;
        div_divisor_d  = div_divisor_q;

        case (state_q)
            S_IDLE: begin
                // done_q marks the cycle after completion; a start there is dropped.
                if (start && !done_q) begin
                    op_x_d  = vec_x;
                    op_d_d  = vec_d;
                    vec_q_d = '0;
                    dz_d    = '0;
                    to_d    = '0;
                    lane_d  = '0;
                    busy_d  = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                div_dividend_d = lane_x;
                div_divisor_d  = lane_dv;
                // The divider also reports idle during its output cycle, so exclude it.
                if (div_idle && !div_update) begin
                    div_valid_d = 1'b1;
                    tmo_d       = '0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (div_update) begin
                    vec_q_d[lane_q*FP16_W +: FP16_W] = div_q;
                    dz_d[lane_q] = is_zero_mag(lane_dv);
                    state_d      = S_NEXT;
                end else if (tmo_q == TW'(TIMEOUT)) begin
                    vec_q_d[lane_q*FP16_W +: FP16_W] =
                        {lane_x[FP16_SIGN] ^ lane_dv[FP16_SIGN], FP16_SAT};
                    to_d[lane_q] = 1'b1;
                    state_d      = S_NEXT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_NEXT: begin
                if (lane_q == LW'(LANES - 1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    lane_d  = lane_q + LW'(1);
                    state_d = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            lane_q         <= '0;
            tmo_q          <= '0;
            op_x_q         <= '0;
            op_d_q         <= '0;
            vec_q_q        <= '0;
            dz_q           <= '0;
            to_q           <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            div_valid_q    <= 1'b0;
            div_dividend_q <= '0;
            div_divisor_q  <= '0;
        end else begin
            state_q        <= state_d;
            lane_q         <= lane_d;
            tmo_q          <= tmo_d;
            op_x_q         <= op_x_d;
            op_d_q         <= op_d_d;
            vec_q_q        <= vec_q_d;
            dz_q           <= dz_d;
            to_q           <= to_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            div_valid_q    <= div_valid_d;
            div_dividend_q <= div_dividend_d;
            div_divisor_q  <= div_divisor_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign vec_q        = vec_q_q;
    assign dz_flag      = dz_q;
    assign to_flag      = to_q;
    assign div_valid    = div_valid_q;
    assign div_dividend = div_dividend_q;
    assign div_divisor  = div_divisor_q;

endmodule

// File: tb/tb_fp16_vdiv_seq.sv
// Directed bench for fp16_vdiv_seq with a fixed-latency divider model standing in for FP16_div.
module tb_fp16_vdiv_seq;

    localparam int LANES    = 4;
    localparam int TIMEOUT  = 15;
    localparam int STUB_LAT = 4;

    localparam logic [63:0] T1X = 64'h3C00_4600_C400_3800;
    localparam logic [63:0] T1D = 64'h4000_4200_4000_3C00;
    localparam logic [63:0] T1Q = 64'h3800_4000_C000_3800;
    localparam logic [63:0] T2X = 64'h3C00_4600_3C00_3800;
    localparam logic [63:0] T2D = 64'h4000_4200_0000_3C00;
    localparam logic [63:0] T2Q = 64'h3800_4000_7FFF_3800;
    localparam logic [63:0] T4X = 64'h4000_4400_4200_3C00;
    localparam logic [63:0] T4D = 64'h3C00_4000_4200_3C00;
    localparam logic [63:0] T4Q = 64'h4000_4000_3C00_3C00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] vec_x = '0;
    logic [63:0] vec_d = '0;
    logic        busy, done, div_valid, div_idle;
    logic [63:0] vec_q;
    logic [3:0]  dz_flag, to_flag;
    logic [15:0] div_dividend, div_divisor, div_q;
    logic        div_update;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fp16_vdiv_seq #(.LANES(LANES), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .vec_x(vec_x), .vec_d(vec_d),
        .busy(busy), .done(done), .vec_q(vec_q), .dz_flag(dz_flag), .to_flag(to_flag),
        .div_dividend(div_dividend), .div_divisor(div_divisor), .div_valid(div_valid),
        .div_idle(div_idle), .div_update(div_update), .div_q(div_q)
    );

    // Divider model: captures operands on the edge ending the valid cycle, answers
    // STUB_LAT+2 cycles later with idle and update both high in the output cycle.
    logic        stub_busy;
    int          stub_cnt;
    logic [15:0] stub_x, stub_d;
    bit          stub_mute = 1'b0;

    assign div_idle = ~stub_busy;

    function automatic logic [15:0] div_model(input logic [15:0] x, input logic [15:0] d);
        if (d[14:0] == 15'd0) return {x[15] ^ d[15], 15'h7FFF};
        case ({x, d})
            32'h3C00_4000: return 16'h3800;
            32'h4600_4200: return 16'h4000;
            32'hC400_4000: return 16'hC000;
            32'h3800_3C00: return 16'h3800;
            32'h4000_3C00: return 16'h4000;
            32'h4400_4000: return 16'h4000;
            32'h4200_4200: return 16'h3C00;
            32'h3C00_3C00: return 16'h3C00;
            default:       return 16'hBAD0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stub_busy  <= 1'b0;
            stub_cnt   <= 0;
            stub_x     <= '0;
            stub_d     <= '0;
            div_update <= 1'b0;
            div_q      <= '0;
        end else begin
            div_update <= 1'b0;
            if (stub_busy) begin
                if (stub_cnt == 0) begin
                    div_update <= 1'b1;
                    div_q      <= div_model(stub_x, stub_d);
                    stub_busy  <= 1'b0;
                end else begin
                    stub_cnt <= stub_cnt - 1;
                end
            end else if (div_valid && !stub_mute) begin
                stub_busy <= 1'b1;
                stub_cnt  <= STUB_LAT;
                stub_x    <= div_dividend;
                stub_d    <= div_divisor;
            end
        end
    end

    // Issue-protocol monitor over the whole run.
    int          mon_valid_cnt = 0;
    int          mon_guard_err = 0;
    int          mon_double    = 0;
    int          mon_stable_err = 0;
    logic        prev_idle = 1'b0, prev_update = 1'b0, prev_valid = 1'b0;
    logic [15:0] lat_x = '0, lat_d = '0;

    always @(negedge clk) begin
        if (rst) begin
            lat_x      = div_dividend;
            lat_d      = div_divisor;
            prev_valid = 1'b0;
        end else begin
            if (div_valid) begin
                mon_valid_cnt++;
                if (!(prev_idle && !prev_update)) mon_guard_err++;
                if (prev_valid) mon_double++;
                lat_x = div_dividend;
                lat_d = div_divisor;
            end else if (div_dividend !== lat_x || div_divisor !== lat_d) begin
                mon_stable_err++;
            end
            prev_valid = div_valid;
        end
        prev_idle   = div_idle;
        prev_update = div_update;
    end

    task automatic do_op(input logic [63:0] x, input logic [63:0] d, output bit seen, output int lat);
        @(negedge clk);
        vec_x = x;
        vec_d = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen  = 1'b0;
        lat   = 1;
        while (!seen && lat < 2000) begin
            if (done) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
        n_cmp++; if (div_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", div_valid); end
        n_cmp++; if (vec_q !== 64'h0) begin n_bad++; $display("FAIL rst_vec_q: got %h want 0", vec_q); end
        n_cmp++; if ({dz_flag, to_flag} !== 8'h0) begin n_bad++; $display("FAIL rst_flags: got %h want 00", {dz_flag, to_flag}); end
        n_cmp++; if ({div_dividend, div_divisor} !== 32'h0) begin n_bad++; $display("FAIL rst_ops: got %h want 0", {div_dividend, div_divisor}); end
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic;
        bit seen;
        int lat;
        int v0;
        v0 = mon_valid_cnt;
        do_op(T1X, T1D, seen, lat);
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL t1_done: no done within %0d cycles", lat); end
        n_cmp++; if (lat !== 37) begin n_bad++; $display("FAIL t1_latency: got %0d want 37", lat); end
        n_cmp++; if (vec_q !== T1Q) begin n_bad++; $display("FAIL t1_q: got %h want %h", vec_q, T1Q); end
        n_cmp++; if ({dz_flag, to_flag} !== 8'h0) begin n_bad++; $display("FAIL t1_flags: got %h want 00", {dz_flag, to_flag}); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t1_busy_at_done: got %b want 0", busy); end
        n_cmp++; if (mon_valid_cnt - v0 !== 4) begin n_bad++; $display("FAIL t1_valid_pulses: got %0d want 4", mon_valid_cnt - v0); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL t1_done_width: got %b want 0", done); end
        n_cmp++; if (vec_q !== T1Q) begin n_bad++; $display("FAIL t1_q_hold: got %h want %h", vec_q, T1Q); end
    endtask

    task automatic test_div_zero;
        bit seen;
        int lat;
        do_op(T2X, T2D, seen, lat);
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL t2_done: no done within %0d cycles", lat); end
        n_cmp++; if (vec_q !== T2Q) begin n_bad++; $display("FAIL t2_q: got %h want %h", vec_q, T2Q); end
        n_cmp++; if (dz_flag !== 4'b0010) begin n_bad++; $display("FAIL t2_dz: got %b want 0010", dz_flag); end
        n_cmp++; if (to_flag !== 4'b0000) begin n_bad++; $display("FAIL t2_to: got %b want 0000", to_flag); end
    endtask

    task automatic test_start_while_busy;
        int ndone;
        int cyc;
        @(negedge clk);
        vec_x = T1X;
        vec_d = T1D;
        start = 1'b1;
        ndone = 0;
        cyc   = 0;
        while (ndone == 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            vec_x = T4X;
            vec_d = T4D;
            if (done) ndone++;
        end
        start = 1'b0;
        n_cmp++; if (ndone !== 1) begin n_bad++; $display("FAIL t3_done: got %0d dones want 1", ndone); end
        n_cmp++; if (vec_q !== T1Q) begin n_bad++; $display("FAIL t3_q: got %h want %h", vec_q, T1Q); end
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        n_cmp++; if (ndone !== 1) begin n_bad++; $display("FAIL t3_extra_done: got %0d dones want 1", ndone); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t3_restart: got busy %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        bit seen;
        int lat;
        do_op(T1X, T1D, seen, lat);
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL b2b_first_done: no done within %0d cycles", lat); end
        vec_x = T4X;
        vec_d = T4D;
        start = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_coincident: got busy %b want 0", busy); end
        n_cmp++; if (vec_q !== T1Q) begin n_bad++; $display("FAIL b2b_q_kept: got %h want %h", vec_q, T1Q); end
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept: got busy %b want 1", busy); end
        n_cmp++; if (vec_q !== 64'h0) begin n_bad++; $display("FAIL b2b_q_clear: got %h want 0", vec_q); end
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < 2000) begin
            @(negedge clk);
            lat++;
            if (done) seen = 1'b1;
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL b2b_second_done: no done within %0d cycles", lat); end
        n_cmp++; if (vec_q !== T4Q) begin n_bad++; $display("FAIL b2b_q: got %h want %h", vec_q, T4Q); end
    endtask

    task automatic test_reset_mid_op;
        bit seen;
        bit done_seen;
        int lat;
        int k;
        int cyc;
        @(negedge clk);
        vec_x = T4X;
        vec_d = T4D;
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        done_seen = 1'b0;
        k   = 0;
        cyc = 0;
        if (div_valid) k++;
        while (k < 3 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (div_valid) k++;
            if (done) done_seen = 1'b1;
        end
        n_cmp++; if (k !== 3) begin n_bad++; $display("FAIL t4_reach_lane2: got %0d issues want 3", k); end
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        n_cmp++; if ({busy, done, div_valid} !== 3'b000) begin n_bad++; $display("FAIL t4_rst_ctl: got %b want 000", {busy, done, div_valid}); end
        n_cmp++; if (vec_q !== 64'h0) begin n_bad++; $display("FAIL t4_rst_q: got %h want 0", vec_q); end
        n_cmp++; if ({div_dividend, div_divisor} !== 32'h0) begin n_bad++; $display("FAIL t4_rst_ops: got %h want 0", {div_dividend, div_divisor}); end
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        n_cmp++; if (done_seen !== 1'b0) begin n_bad++; $display("FAIL t4_no_done: got done %b want 0", done_seen); end
        do_op(T4X, T4D, seen, lat);
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL t4_fresh_done: no done within %0d cycles", lat); end
        n_cmp++; if (vec_q !== T4Q) begin n_bad++; $display("FAIL t4_fresh_q: got %h want %h", vec_q, T4Q); end
    endtask

    task automatic test_timeout;
        int t[4];
        int k;
        int cyc;
        bit seen;
        @(negedge clk);
        stub_mute = 1'b1;
        vec_x = {4{16'hBC00}};
        vec_d = {4{16'h4000}};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k    = 0;
        cyc  = 0;
        seen = 1'b0;
        foreach (t[i]) t[i] = 0;
        while (!seen && cyc < 2000) begin
            if (div_valid) begin
                if (k < 4) t[k] = cyc;
                k++;
            end
            if (done) seen = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        stub_mute = 1'b0;
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL t5_done: no done within %0d cycles", cyc); end
        n_cmp++; if (k !== 4) begin n_bad++; $display("FAIL t5_issues: got %0d want 4", k); end
        n_cmp++; if (t[1] - t[0] !== 18) begin n_bad++; $display("FAIL t5_spacing01: got %0d want 18", t[1] - t[0]); end
        n_cmp++; if (t[3] - t[2] !== 18) begin n_bad++; $display("FAIL t5_spacing23: got %0d want 18", t[3] - t[2]); end
        n_cmp++; if (vec_q !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL t5_q: got %h want ffffffffffffffff", vec_q); end
        n_cmp++; if (to_flag !== 4'b1111) begin n_bad++; $display("FAIL t5_to: got %b want 1111", to_flag); end
        n_cmp++; if (dz_flag !== 4'b0000) begin n_bad++; $display("FAIL t5_dz: got %b want 0000", dz_flag); end
    endtask

    task automatic test_valid_protocol;
        @(negedge clk);
        n_cmp++; if (mon_valid_cnt < 20) begin n_bad++; $display("FAIL t6_activity: got %0d pulses want >=20", mon_valid_cnt); end
        n_cmp++; if (mon_guard_err !== 0) begin n_bad++; $display("FAIL t6_guard: got %0d bad issues want 0", mon_guard_err); end
        n_cmp++; if (mon_double !== 0) begin n_bad++; $display("FAIL t6_single_pulse: got %0d wide pulses want 0", mon_double); end
        n_cmp++; if (mon_stable_err !== 0) begin n_bad++; $display("FAIL t6_stable_ops: got %0d changes want 0", mon_stable_err); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_div_zero;
        test_start_while_busy;
        test_back_to_back;
        test_reset_mid_op;
        test_timeout;
        test_valid_protocol;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
